// File: rtl/pulse_stretcher_universal.sv
// pulse_stretcher_universal
//   Turns 1-clk trigger pulses into fixed-width output pulses (LED flash, DAC gate,
//   buzzer enable). Each channel runs an independent IDLE/ACTIVE/GAP FSM: the output
//   stays high for PULSE_LEN clocks, then the channel is forced low (busy) for
//   GAP_LEN clocks before it accepts another trigger.
//
//   Build option: define RETRIGGER_EN to let a trigger during ACTIVE restart the
//   high time instead of being dropped. Triggers during GAP are always dropped.
//
// Ports
//   clk          in   1      system clock
//   rst          in   1      asynchronous active-low reset
//   trig_i       in   WIDTH  per-channel request, sampled every posedge
//   pulse_out_o  out  WIDTH  stretched pulse (registered)
//   busy_o       out  WIDTH  channel is ACTIVE or GAP (registered)
//   drop_o       out  WIDTH  1-clk flag: the trigger seen on the previous edge was ignored
module pulse_stretcher_universal #(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned PULSE_LEN = 1000000,
    parameter int unsigned GAP_LEN   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] trig_i,
    output logic [WIDTH-1:0] pulse_out_o,
    output logic [WIDTH-1:0] busy_o,
    output logic [WIDTH-1:0] drop_o
);

    localparam int unsigned MaxLen = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int unsigned CNT_W  = $clog2(MaxLen + 1);

    localparam logic [CNT_W-1:0] PulseLoad = CNT_W'(PULSE_LEN - 1);
    // GAP_LEN=0 never enters GAP; keep the load value from underflowing anyway.
    localparam logic [CNT_W-1:0] GapLoad   = (GAP_LEN == 0) ? '0 : CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StGap
    } state_e;

    state_e           state_q [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [WIDTH-1:0] pulse_q;
    logic [WIDTH-1:0] busy_q;
    logic [WIDTH-1:0] drop_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
            end
            pulse_q <= '0;
            busy_q  <= '0;
            drop_q  <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                drop_q[i] <= 1'b0;
                case (state_q[i])
                    StIdle: begin
                        if (trig_i[i]) begin
                            state_q[i] <= StActive;
                            cnt_q[i]   <= PulseLoad;
                            pulse_q[i] <= 1'b1;
                            busy_q[i]  <= 1'b1;
                        end else begin
                            cnt_q[i]   <= '0;
                            pulse_q[i] <= 1'b0;
                            busy_q[i]  <= 1'b0;
                        end
                    end

                    StActive: begin
`ifdef RETRIGGER_EN
                        // A new request restarts the full high time.
                        if (trig_i[i]) begin
                            cnt_q[i] <= PulseLoad;
                        end else if (cnt_q[i] != '0) begin
`else
                        drop_q[i] <= trig_i[i];
                        if (cnt_q[i] != '0) begin
`endif
                            cnt_q[i] <= cnt_q[i] - CntOne;
                        end else if (GAP_LEN == 0) begin
                            state_q[i] <= StIdle;
                            pulse_q[i] <= 1'b0;
                            busy_q[i]  <= 1'b0;
                        end else begin
                            state_q[i] <= StGap;
                            cnt_q[i]   <= GapLoad;
                            pulse_q[i] <= 1'b0;
                        end
                    end

                    StGap: begin
                        drop_q[i] <= trig_i[i];
                        if (cnt_q[i] != '0) begin
                            cnt_q[i] <= cnt_q[i] - CntOne;
                        end else begin
                            state_q[i] <= StIdle;
                            busy_q[i]  <= 1'b0;
                        end
                    end

                    default: begin
                        state_q[i] <= StIdle;
                        cnt_q[i]   <= '0;
                        pulse_q[i] <= 1'b0;
                        busy_q[i]  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pulse_out_o = pulse_q;
    assign busy_o      = busy_q;
    assign drop_o      = drop_q;

endmodule
